// File: rtl/xy_route_ctrl.sv
// xy_route_ctrl: five independent per-input-port route controllers for a 2D mesh
// router using dimension-ordered (X first, then Y) routing.
//
// Each port latches a route when its head flit arrives. It holds that route until
// the tail flit has been transferred, then returns to idle.
//
// Port / channel encoding: LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4.
//
// Parameters:
//   ROUTER_ID   linear ID of this router (row = ID / MESH_X, col = ID % MESH_X)
//   MESH_X      mesh columns (column index grows eastward)
//   MESH_Y      mesh rows (row index grows southward)
//   ADDR_WIDTH  width of one destination ID
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   dest        per-port destination IDs, slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
//   head_valid  per-port head flit present
//   tail_done   per-port pulse: tail flit transferred
//   rout        per-port 3-bit output channel, slice i = [i*3 +: 3]
//   rout_valid  per-port route held
//   dest_err    per-port out-of-range destination pulse
//
// Optional feature macro: ROUTE_DEST_CHECK_EN.
//   When it is defined, a head whose destination lies outside the mesh is not
//   routed. It raises a one-cycle dest_err, and the port stays idle.
//   When it is undefined, dest_err is tied to 0 and every destination is routed.

module xy_route_port #(
    parameter int ROUTER_ID  = 0,
    parameter int MESH_X     = 4,
    parameter int MESH_Y     = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dest,
    input  logic                  head_valid,
    input  logic                  tail_done,
    output logic [2:0]            rout,
    output logic                  rout_valid,
    output logic                  dest_err
);
    localparam logic [2:0] CH_LOCAL = 3'd0;
    localparam logic [2:0] CH_NORTH = 3'd1;
    localparam logic [2:0] CH_SOUTH = 3'd2;
    localparam logic [2:0] CH_EAST  = 3'd3;
    localparam logic [2:0] CH_WEST  = 3'd4;

    localparam int unsigned OWN_COL = ROUTER_ID % MESH_X;
    localparam int unsigned OWN_ROW = (ROUTER_ID / MESH_X) % MESH_Y;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [2:0]  rout_q, route_d;
    logic        lock;
    logic        bad_dest;
    logic        err_d;
    int unsigned dcol, drow;

    // XY route: resolve the column first, then the row. The compares are unsigned,
    // so no arithmetic can wrap.
    always_comb begin
        dcol    = 32'(dest) % 32'(MESH_X);
        drow    = 32'(dest) / 32'(MESH_X);
        route_d = CH_LOCAL;
        if (dcol > OWN_COL)      route_d = CH_EAST;
        else if (dcol < OWN_COL) route_d = CH_WEST;
        else if (drow > OWN_ROW) route_d = CH_SOUTH;
        else if (drow < OWN_ROW) route_d = CH_NORTH;
    end

`ifdef ROUTE_DEST_CHECK_EN
    assign bad_dest = (32'(dest) >= 32'(MESH_X * MESH_Y));
`else
    assign bad_dest = 1'b0;
`endif

    // State register. The route register is written only when the port locks, so
    // the route keeps its last value after the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rout_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            if (lock) rout_q <= route_d;
        end
    end

    // Next state. A head that arrives on the tail edge is deliberately dropped.
    // The port re-samples heads only once it is back in IDLE.
    always_comb begin
        state_d = state_q;
        lock    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_valid) begin
                    if (bad_dest) begin
                        err_d = 1'b1;
                    end else begin
                        lock    = 1'b1;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (tail_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ROUTE_DEST_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`endif

    // Outputs
    always_comb begin
        rout       = rout_q;
        rout_valid = (state_q == LOCKED);
`ifdef ROUTE_DEST_CHECK_EN
        dest_err   = err_q;
`else
        dest_err   = 1'b0;
`endif
    end

`ifndef ROUTE_DEST_CHECK_EN
    // With the check disabled, the error term is never consumed.
    logic unused_err;
    assign unused_err = err_d;
`endif
endmodule

module xy_route_ctrl #(
    parameter int ROUTER_ID  = 0,
    parameter int MESH_X     = 4,
    parameter int MESH_Y     = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5*ADDR_WIDTH-1:0] dest,
    input  logic [4:0]              head_valid,
    input  logic [4:0]              tail_done,
    output logic [14:0]             rout,
    output logic [4:0]              rout_valid,
    output logic [4:0]              dest_err
);
    for (genvar i = 0; i < 5; i++) begin : g_port
        xy_route_port #(
            .ROUTER_ID (ROUTER_ID),
            .MESH_X    (MESH_X),
            .MESH_Y    (MESH_Y),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .dest      (dest[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .head_valid(head_valid[i]),
            .tail_done (tail_done[i]),
            .rout      (rout[i*3 +: 3]),
            .rout_valid(rout_valid[i]),
            .dest_err  (dest_err[i])
        );
    end
endmodule
